// File: rtl/key_rx.sv
// PS/2 keyboard receiver: decodes 11-bit frames, folds E0/F0 prefixes into a one-cycle key event word.
// Build option: define KEY_RX_BREAK_REPORT_EN to report break (key release) events as well as makes.
module key_rx #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keyboard,
    output logic        frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic             ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
    logic             ps2_data_s1_q, ps2_data_s2_q;

    logic [1:0]       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_ok_q, parity_ok_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [31:0]      keyboard_q, keyboard_d;
    logic             frame_err_q, frame_err_d;

    logic             fall;
    logic             bit_s;
    logic [CNT_W-1:0] tmo_inc;

    // Synchronizers idle high so an undriven (pulled-up) bus never looks like an edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_s1_q   <= 1'b1;
            ps2_clk_s2_q   <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_data_s1_q  <= 1'b1;
            ps2_data_s2_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its source.
            ps2_clk_s1_q   <= ps2_clk;
            ps2_clk_s2_q   <= ps2_clk_s1_q;
            ps2_clk_prev_q <= ps2_clk_s2_q;
            ps2_data_s1_q  <= ps2_data;
            ps2_data_s2_q  <= ps2_data_s1_q;
        end
    end

    assign fall    = ps2_clk_prev_q & ~ps2_clk_s2_q;
    assign bit_s   = ps2_data_s2_q;
    assign tmo_inc = tmo_q + CNT_W'(1);

    always_comb begin
        // NOTE: every next-state signal gets a default first, otherwise untaken branches infer latches.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_ok_d = parity_ok_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        tmo_d       = tmo_q;
        keyboard_d  = '0;
        frame_err_d = 1'b0;

        if (fall) begin
            // An edge always wins over a simultaneous timeout.
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!bit_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {bit_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    parity_ok_d = ^{shift_q, bit_s};
                    state_d     = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (parity_ok_q && bit_s) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
`ifdef KEY_RX_BREAK_REPORT_EN
                            keyboard_d = {22'b0, brk_q, ext_q, shift_q};
`else
                            if (!brk_q) keyboard_d = {22'b0, 1'b0, ext_q, shift_q};
`endif
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_inc == CNT_W'(TIMEOUT_CYC)) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
                bit_cnt_d   = '0;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            tmo_q       <= '0;
            keyboard_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_ok_q <= parity_ok_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            tmo_q       <= tmo_d;
            keyboard_q  <= keyboard_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign keyboard  = keyboard_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/key_rx.md
KEY_RX -- requirements
Module: key_rx

Interface
REQ-001 Parameter TIMEOUT_CYC, default 20000: idle clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-006 keyboard  output  32  key event word; non-zero for exactly one clk cycle per reported event, zero otherwise; drives the register file's keyboard input.
REQ-007 frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-008 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synchronized ps2_clk going 1 to 0 between consecutive clk cycles.
REQ-009 All frame bits SHALL be sampled from synchronized ps2_data in the clk cycle in which the falling edge is detected.
REQ-010 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-011 IDLE: on a falling edge, sampled 0 goes to DATA with the bit counter at 0; sampled 1 stays in IDLE and pulses frame_err.
REQ-012 DATA: each falling edge shifts the sampled bit into the scancode, LSB first; after the 8th bit, go to PARITY.
REQ-013 PARITY: the sampled bit SHALL make the 9-bit total of data plus parity odd; otherwise flag a parity error; go to STOP in either case.
REQ-014 STOP: the sampled bit SHALL be 1; then return to IDLE.
REQ-015 A frame is good only when parity and stop are both correct; on a bad frame, pulse frame_err, clear the prefix flags and emit no keyboard word.
REQ-016 Good byte 0xE0 SHALL set the ext flag; good byte 0xF0 SHALL set the brk flag; neither emits a word.
REQ-017 Any other good byte SHALL emit keyboard = {22'b0, brk, ext, scancode[7:0]} in the clk cycle after the STOP sample, then clear both flags.
REQ-018 The timeout counter SHALL reset on every falling edge and count only outside IDLE.
REQ-019 When the timeout counter reaches TIMEOUT_CYC: return to IDLE, pulse frame_err, clear the flags and the bit counter.
REQ-020 keyboard and frame_err SHALL never be asserted in the same cycle.
REQ-021 A falling edge in the same cycle as the timeout SHALL be processed as a bit, and the timeout SHALL NOT fire.
REQ-022 Scancode 0x00 with no flags SHALL emit 32'h0, which is indistinguishable from no event; this is accepted behaviour.

Reset
REQ-023 While rst_n=0: keyboard=0, frame_err=0, FSM=IDLE, bit counter=0, timeout counter=0, ext=brk=0, shift register=0, synchronizer flops=1.
REQ-024 Deassertion of reset mid-frame SHALL start cleanly in IDLE; the partial frame is discarded without frame_err.

Configuration
REQ-025 Macro KEY_RX_BREAK_REPORT_EN defined: break events are emitted per REQ-017 with bit 9 set.
REQ-026 Macro KEY_RX_BREAK_REPORT_EN undefined: a good non-prefix byte with brk=1 SHALL clear the flags and emit nothing; only make events reach keyboard.

Verification
REQ-027 Frame 0x1C, odd parity 0, stop 1 -> keyboard=32'h0000001C for one cycle, frame_err never asserted.
REQ-028 Frames E0, 75 -> a single word 32'h00000175.
REQ-029 Frames F0, 1C -> with the macro, 32'h0000021C; without the macro, no word.
REQ-030 Frame 0x1C with parity 1 -> frame_err pulse, no word; then a following good frame 0x1C -> 32'h0000001C, with the flags confirmed cleared.
REQ-031 Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYC cycles -> one frame_err pulse, FSM back in IDLE; the next full frame 0x29 -> 32'h00000029.
REQ-032 rst_n pulsed low after 5 bits of a frame -> all outputs 0 during reset, no frame_err afterwards, and the next good frame decodes correctly.
